// File: rtl/tone_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_pkg : shared width defaults and the mixer's saturating add
// Revision : 1.0
// ---------------------------------------------------------------------------
package tone_pkg;

  localparam int AMP_W_DEF = 16;
  localparam int DIV_W_DEF = 27;

  // Adds two sign-extended operands and clamps the result to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_channel : one square-wave oscillator with linear envelope and sample register
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tone_channel
  import tone_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int AMP_W     = AMP_W_DEF,
  parameter int RAMP_STEP = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [DIV_W-1:0] div,
  input  logic [AMP_W-2:0] vol,
  input  logic             en,
  output logic [AMP_W-1:0] audio,
  output logic             busy
);

  localparam logic [AMP_W-1:0] STEP = AMP_W'(RAMP_STEP);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] adiv;
  logic             ph;
  logic [AMP_W-2:0] amp;
  logic [AMP_W-2:0] amp_nxt;
  logic [AMP_W-1:0] amp_up;
  logic [AMP_W-1:0] amp_dn;
  logic [AMP_W-1:0] vol_x;

  // Guard bit: amp_dn MSB set means the subtraction went below zero.
  assign vol_x  = {1'b0, vol};
  assign amp_up = {1'b0, amp} + STEP;
  assign amp_dn = {1'b0, amp} - STEP;

  always_comb begin
    amp_nxt = amp;
    if (!en)
      amp_nxt = amp_dn[AMP_W-1] ? '0 : amp_dn[AMP_W-2:0];
    else if (amp < vol)
      amp_nxt = (amp_up > vol_x) ? vol : amp_up[AMP_W-2:0];
    else if (amp > vol)
      amp_nxt = (amp_dn[AMP_W-1] || (amp_dn < vol_x)) ? vol : amp_dn[AMP_W-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      adiv  <= '0;
      ph    <= 1'b0;
      amp   <= '0;
      audio <= '0;
    end else begin
      // New divisors are only adopted at a wrap or while idle.
      if (adiv == '0) begin
        cnt  <= '0;
        ph   <= 1'b0;
        adiv <= div;
      end else if (cnt == adiv - 1'b1) begin
        cnt  <= '0;
        ph   <= ~ph;
        adiv <= div;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (tick)
        amp <= amp_nxt;

      if ((adiv == '0) || (amp == '0))
        audio <= '0;
      else if (ph)
        audio <= {1'b0, amp};
      else
        audio <= -{1'b0, amp};
    end
  end

  assign busy = (amp != '0);

endmodule
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_synth : multi-channel square-wave tone generator with saturating mixer
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tone_synth
  import tone_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int AMP_W     = AMP_W_DEF,
  parameter int RAMP_DIV  = 1024,
  parameter int RAMP_STEP = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*DIV_W-1:0]   div,
  input  logic [NCH*(AMP_W-1)-1:0] vol,
  input  logic [NCH-1:0]         en,
  output logic [NCH*AMP_W-1:0]   audio,
  output logic [AMP_W-1:0]       audio_mix,
  output logic [NCH-1:0]         busy
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int MIX_W = AMP_W + ((NCH > 1) ? $clog2(NCH) : 0);

  logic [PRE_W-1:0]        pre;
  logic                    tick;
  logic signed [MIX_W-1:0] part;

  assign tick = (pre == PRE_W'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tone_channel #(
      .DIV_W    (DIV_W),
      .AMP_W    (AMP_W),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .div  (div[i*DIV_W +: DIV_W]),
      .vol  (vol[i*(AMP_W-1) +: (AMP_W-1)]),
      .en   (en[i]),
      .audio(audio[i*AMP_W +: AMP_W]),
      .busy (busy[i])
    );
  end

  // Exact sum of all but the last channel; the last is folded in by the clamp.
  always_comb begin
    part = '0;
    for (int i = 0; i < NCH - 1; i++)
      part = part + MIX_W'($signed(audio[i*AMP_W +: AMP_W]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      audio_mix <= '0;
    else
      audio_mix <= AMP_W'(sat_add(64'(part),
                                  64'($signed(audio[(NCH-1)*AMP_W +: AMP_W])),
                                  AMP_W));
  end

endmodule
`default_nettype wire
